// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg -- shared core definitions
//
// Purpose : types and constants shared by the fetch unit and the opcode
//           decoder: fetch FSM state encoding, the canonical NOP word,
//           the sequential pc step, and the 7-bit major opcode values.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_REG    = 7'b011_0011;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- single-outstanding instruction fetch stage
//
// Purpose : issues one word fetch at a time, registers the returned word,
//           holds it until decode accepts it, and handles redirects from
//           execute, including dropping the data of a fetch that was already
//           in flight when the redirect arrived.
// Ports   :
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req / imem_addr     fetch request and word address (held until ack)
//   imem_ack / imem_rdata    one-cycle completion strobe and its data
//   redirect / redirect_pc   one-cycle jump/branch target from execute
//   dec_ready                decode accepts the held instruction
//   inst_valid/inst/inst_pc  held instruction and its address
//   op                       inst[6:0] for the opcode decoder
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  op
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    // Address of the request still in flight when kill is set; pc_q has
    // already moved on to the redirect target by then.
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            kill_addr_q <= '0;
            inst_q      <= NOP_INST;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            kill_addr_q <= kill_addr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                // Redirects are ignored here; pc is already RESET_PC.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_ack) begin
                    // The outstanding fetch completes; kill is spent either way.
                    kill_d = 1'b0;
                    if (redirect) begin
                        pc_d = word_align(redirect_pc);
                    end else if (!kill_q) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Keep presenting the in-flight address until its ack;
                    // only the first redirect captures it, later ones just
                    // retarget pc.
                    pc_d   = word_align(redirect_pc);
                    kill_d = 1'b1;
                    if (!kill_q) begin
                        kill_addr_d = pc_q;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = ST_FETCH;
                end else if (dec_ready) begin
                    pc_d    = inst_pc_q + PC_STEP;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = kill_q ? kill_addr_q : pc_q;
    assign inst_valid = (state_q == ST_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign op         = inst_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit
//
// Purpose : drives a linear sequence of fetch, hold, redirect and reset
//           scenarios and compares outputs against hand-derived values.
//           A second instance with RESET_PC = 0xFFFF_FFFC covers pc wrap.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  op;

    // Wrap instance (RESET_PC = 0xFFFF_FFFC)
    logic        rst_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        dec_ready_w;
    logic        inst_valid_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic [6:0]  op_w;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_ready  (dec_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .op         (op)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk        (clk),
        .rst        (rst_w),
        .imem_req   (imem_req_w),
        .imem_addr  (imem_addr_w),
        .imem_ack   (imem_ack_w),
        .imem_rdata (imem_rdata_w),
        .redirect   (redirect_w),
        .redirect_pc(redirect_pc_w),
        .dec_ready  (dec_ready_w),
        .inst_valid (inst_valid_w),
        .inst       (inst_w),
        .inst_pc    (inst_pc_w),
        .op         (op_w)
    );

    // Memory contents: distinct per address, opcode field always 7'h33.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h33} ^ 32'hC000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait (at falling edges) for the main instance to request.
    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req"}, {31'b0, imem_req}, 32'd1);
    endtask

    // Serve one fetch with the ack in the second request cycle, then check
    // the registered instruction one cycle after the ack.
    task automatic serve(input logic [31:0] a, input string tag);
        wait_req(tag);
        check({tag, " addr"}, imem_addr, a);
        @(negedge clk);
        check({tag, " addr held"}, imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(a);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({tag, " valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, " inst"}, inst, mem_word(a));
        check({tag, " inst_pc"}, inst_pc, a);
        check({tag, " op"}, {25'b0, op}, 32'h33);
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        dec_ready     = 1'b1;
        rst_w         = 1'b1;
        imem_ack_w    = 1'b0;
        imem_rdata_w  = '0;
        redirect_w    = 1'b0;
        redirect_pc_w = '0;
        dec_ready_w   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst req", {31'b0, imem_req}, 32'd0);
        check("rst valid", {31'b0, inst_valid}, 32'd0);
        check("rst inst", inst, NOP_INST);
        check("rst inst_pc", inst_pc, 32'd0);
        check("rst op", {25'b0, op}, 32'h13);

        // Release: one IDLE cycle, then sequential fetches
        rst = 1'b0;
        #1 check("idle req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("first req addr", imem_addr, 32'h0);
        serve(32'h0, "seq0");
        @(negedge clk);
        dec_ready = 1'b0;
        serve(32'h4, "seq4");

        // Stall in HOLD for five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall inst", inst, mem_word(32'h4));
            check("stall valid", {31'b0, inst_valid}, 32'd1);
            check("stall req", {31'b0, imem_req}, 32'd0);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        check("release valid", {31'b0, inst_valid}, 32'd0);
        check("release addr", imem_addr, 32'h8);
        dec_ready = 1'b0;
        serve(32'h8, "seq8");

        // Redirect in HOLD overrides dec_ready; low target bits dropped
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        dec_ready   = 1'b1;
        @(negedge clk);
        redirect  = 1'b0;
        dec_ready = 1'b0;
        check("hold redir valid", {31'b0, inst_valid}, 32'd0);
        check("hold redir req", {31'b0, imem_req}, 32'd1);
        check("hold redir addr", imem_addr, 32'h100);

        // Redirect one cycle into a 3-cycle fetch of 0x100
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        check("kill addr held", imem_addr, 32'h100);
        check("kill req held", {31'b0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h100);
        @(negedge clk);
        imem_ack = 1'b0;
        check("kill drop valid", {31'b0, inst_valid}, 32'd0);
        check("kill refetch req", {31'b0, imem_req}, 32'd1);
        check("kill refetch addr", imem_addr, 32'h200);

        // Redirect and ack in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(32'h200);
        @(negedge clk);
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("same drop valid", {31'b0, inst_valid}, 32'd0);
        check("same refetch addr", imem_addr, 32'h300);
        dec_ready = 1'b1;
        serve(32'h300, "same300");

        // Two redirects while kill is set: last target wins
        @(negedge clk);
        check("seq304 addr", imem_addr, 32'h304);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        @(negedge clk);
        redirect_pc = 32'h0000_0502;
        check("double addr held a", imem_addr, 32'h304);
        @(negedge clk);
        redirect = 1'b0;
        check("double addr held b", imem_addr, 32'h304);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h304);
        @(negedge clk);
        imem_ack = 1'b0;
        check("double drop valid", {31'b0, inst_valid}, 32'd0);
        check("double target addr", imem_addr, 32'h500);
        serve(32'h500, "last500");

        // Reset during an outstanding fetch
        @(negedge clk);
        check("pre-rst req", {31'b0, imem_req}, 32'd1);
        check("pre-rst addr", imem_addr, 32'h504);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h504);
        #1;
        check("rst mid req", {31'b0, imem_req}, 32'd0);
        check("rst mid valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0700;
        #1 check("rst idle req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
        check("restart valid", {31'b0, inst_valid}, 32'd0);
        check("restart addr", imem_addr, 32'h0);
        serve(32'h0, "restart0");

        // pc wrap on the second instance
        rst_w = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wrap req", {31'b0, imem_req_w}, 32'd1);
        check("wrap addr", imem_addr_w, 32'hFFFF_FFFC);
        imem_ack_w   = 1'b1;
        imem_rdata_w = mem_word(32'hFFFF_FFFC);
        @(negedge clk);
        imem_ack_w = 1'b0;
        check("wrap valid", {31'b0, inst_valid_w}, 32'd1);
        check("wrap inst", inst_w, 32'h3FFF_FC33);
        check("wrap inst_pc", inst_pc_w, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap next req", {31'b0, imem_req_w}, 32'd1);
        check("wrap next addr", imem_addr_w, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
